rr_pop_controller: RTL

Consumer side of the weighted round-robin arbiter: takes the arbiter's `selector`/`selector_enb` grant and turns it into a one-hot pop to the selected FIFO. It captures the FIFO's read data one cycle later and presents it downstream through a 2-entry output buffer with a valid/ready handshake. It sits between the per-queue FIFO bank and the egress port, and guarantees no pop is issued to an empty queue or without buffer space.

---
 rtl/rr_pop_controller_if.sv | 29 ++
 rtl/rr_pop_controller.sv | 113 +++++++++++
 2 files changed

// File: rtl/rr_pop_controller_if.sv
// Bus bundle between the arbiter/FIFO bank, the pop controller and the egress port.
// The slave modport is the controller's view; master is the surrounding environment.
interface rr_pop_controller_if #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8
);
    localparam int SEL_BITS = $clog2(QUEUE_QUANTITY);

    logic                                enb;
    logic                                selector_enb;
    logic [SEL_BITS-1:0]                 selector;
    logic [QUEUE_QUANTITY-1:0]           buf_empty;
    logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data;
    logic                                out_ready;
    logic [QUEUE_QUANTITY-1:0]           pop;
    logic [DATA_BITS-1:0]                data_out;
    logic                                data_valid;
    logic                                err_underrun;

    modport master (
        output enb, selector_enb, selector, buf_empty, fifo_data, out_ready,
        input  pop, data_out, data_valid, err_underrun
    );

    modport slave (
        input  enb, selector_enb, selector, buf_empty, fifo_data, out_ready,
        output pop, data_out, data_valid, err_underrun
    );
endinterface

// File: rtl/rr_pop_controller.sv
// Turns an arbiter grant into a one-hot FIFO pop, captures the returned word a cycle
// later and presents it through a 2-entry valid/ready output buffer.
module rr_pop_controller #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8
) (
    input logic               clk,
    input logic               rst,
    rr_pop_controller_if.slave bus
);
    localparam int SEL_BITS = $clog2(QUEUE_QUANTITY);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e                      occ_q, occ_d;
    logic                      inflight_q, inflight_d;
    logic [SEL_BITS-1:0]       sel_pipe_q, sel_pipe_d;
    logic [DATA_BITS-1:0]      head_q, head_d;
    logic [DATA_BITS-1:0]      tail_q, tail_d;
    logic                      valid_q, valid_d;
    logic                      err_q, err_d;

    logic                      grant;
    logic                      req;
    logic                      deq;
    logic                      space;
    logic [2:0]                pending;
    logic [DATA_BITS-1:0]      cap_word;
    logic [QUEUE_QUANTITY-1:0] pop;

    // Credit check counts the word already in flight so a pop never lands without a slot.
    // NOTE: every signal written in an always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        grant   = bus.enb & bus.selector_enb;
        req     = grant & ~bus.buf_empty[bus.selector];
        deq     = valid_q & bus.out_ready;
        pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, deq};
        space   = pending < 3'd2;
        pop     = '0;
        if (req && space) begin
            pop[bus.selector] = 1'b1;
        end
    end

    always_comb begin
        cap_word   = bus.fifo_data[sel_pipe_q*DATA_BITS +: DATA_BITS];
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = |pop;
        sel_pipe_d = bus.selector;
        err_d      = grant & bus.buf_empty[bus.selector];

        case ({inflight_q, deq})
            2'b10: begin
                case (occ_q)
                    EMPTY:   begin head_d = cap_word; occ_d = ONE;  end
                    ONE:     begin tail_d = cap_word; occ_d = FULL; end
                    default: occ_d = occ_q;
                endcase
            end
            2'b01: begin
                case (occ_q)
                    ONE:     occ_d = EMPTY;
                    FULL:    begin head_d = tail_q; occ_d = ONE; end
                    default: occ_d = occ_q;
                endcase
            end
            2'b11: begin
                // Head advances and the new word takes the freed slot; occupancy is unchanged.
                case (occ_q)
                    ONE:     head_d = cap_word;
                    FULL:    begin head_d = tail_q; tail_d = cap_word; end
                    default: occ_d = occ_q;
                endcase
            end
            default: occ_d = occ_q;
        endcase

        valid_d = (occ_d != EMPTY);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q      <= EMPTY;
            inflight_q <= 1'b0;
            sel_pipe_q <= '0;
            head_q     <= '0;
            // NOTE: the buffer storage is reset too, so data_out reads a defined zero after reset.
            tail_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            sel_pipe_q <= sel_pipe_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.pop          = pop;
    assign bus.data_out     = head_q;
    assign bus.data_valid   = valid_q;
    assign bus.err_underrun = err_q;
endmodule
